count_seq: RTL and testbench

COUNT_SEQ -- requirements
Module: count_seq

---
 rtl/count_seq_if.sv | 28 ++
 rtl/count_seq.sv | 113 +++++++++++
 tb/tb_count_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_if.sv
// Interface bundling the target handshake, counter feedback and status
// signals of the count sequencer. The sequencer is the slave; the
// environment (target source plus up/down counter) is the master.
interface count_seq_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_valid;
  logic             tgt_ready;
  logic             abort;
  logic [WIDTH-1:0] cur_data;
  logic             en;
  logic             up;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] steps;

  modport slave (
    input  tgt_data, tgt_valid, abort, cur_data,
    output tgt_ready, en, up, busy, done, aborted, steps
  );

  modport master (
    output tgt_data, tgt_valid, abort, cur_data,
    input  tgt_ready, en, up, busy, done, aborted, steps
  );
endinterface

// File: rtl/count_seq.sv
// Count sequencer: accepts a target value and steers an external up/down
// counter to it along the shortest modular path, counting the steps taken.
// en/up are combinational so the counter stops exactly on the target;
// done/aborted are registered one-cycle pulses.
module count_seq #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  count_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Half of the modular range: a distance of exactly this much counts up.
  localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] target_q,  target_d;
  logic [WIDTH-1:0] steps_q,   steps_d;
  logic             done_q,    done_d;
  logic             aborted_q, aborted_d;

  logic             at_target_s;
  logic             en_s;
  logic             up_s;
  logic [WIDTH-1:0] diff_s;

  // Steering: enable only while running, off target and not aborting;
  // direction picks the shorter way round the modular ring.
  always_comb begin
    at_target_s = (bus.cur_data == target_q);
    diff_s      = target_q - bus.cur_data;
    en_s        = (state_q == S_RUN) && !at_target_s && !bus.abort;
    if (en_s && (diff_s <= HALF)) begin
      up_s = 1'b1;
    end else begin
      up_s = 1'b0;
    end
  end

  // Next-state and datapath: handshake, step counting, completion and abort.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    steps_d   = steps_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.tgt_valid) begin
          target_d = bus.tgt_data;
          steps_d  = ZERO;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (at_target_s) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else if (steps_q != ALL_ONES) begin
          steps_d = steps_q + ONE;
        end else begin
          steps_d = steps_q;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      target_q  <= ZERO;
      steps_q   <= ZERO;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      steps_q   <= steps_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.tgt_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.en        = en_s;
  assign bus.up        = up_s;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.steps     = steps_q;

endmodule

// File: tb/tb_count_seq.sv
// Directed bench: count_seq paired with a behavioural up/down counter whose
// output is fed back as cur_data. Expected values are hand-computed.
module tb_count_seq;

  logic        clk;
  logic        reset;
  logic        ld;
  logic [15:0] ld_val;
  logic [15:0] cnt;
  int          tests;
  int          fails;

  count_seq_if #(.WIDTH(16)) bus ();

  count_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Up/down counter driven by the sequencer's en/up, loadable by the bench.
  always_ff @(posedge clk) begin
    if (ld) begin
      cnt <= ld_val;
    end else if (bus.en) begin
      cnt <= bus.up ? cnt + 16'd1 : cnt - 16'd1;
    end
  end

  assign bus.cur_data = cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cnt(input logic [15:0] v);
    @(negedge clk);
    ld = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic move(input logic [15:0] tgt, input int bound,
                      output int en_cnt, output int up_cnt,
                      output int done_cnt, output int ab_cnt);
    int cyc;
    @(negedge clk);
    bus.tgt_data  = tgt;
    bus.tgt_valid = 1'b1;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    en_cnt = 0; up_cnt = 0; done_cnt = 0; ab_cnt = 0; cyc = 0;
    while (bus.busy && cyc < bound) begin
      if (bus.en)      en_cnt++;
      if (bus.up)      up_cnt++;
      if (bus.done)    done_cnt++;
      if (bus.aborted) ab_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk("move_in_time", (cyc < bound) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_cnt(input logic [15:0] v, input int bound);
    int cyc;
    cyc = 0;
    while (cnt != v && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_cnt_in_time", (cyc < bound) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int e, u, d, a;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    ld = 1'b1;
    ld_val = 16'd0;
    bus.tgt_data  = 16'd0;
    bus.tgt_valid = 1'b0;
    bus.abort     = 1'b0;

    // Reset state, before any clock edge.
    #1;
    chk("rst_ready",   32'(bus.tgt_ready), 32'd1);
    chk("rst_busy",    32'(bus.busy),      32'd0);
    chk("rst_en",      32'(bus.en),        32'd0);
    chk("rst_up",      32'(bus.up),        32'd0);
    chk("rst_done",    32'(bus.done),      32'd0);
    chk("rst_aborted", 32'(bus.aborted),   32'd0);
    chk("rst_steps",   32'(bus.steps),     32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ld = 1'b0;

    // Abort in IDLE is ignored.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idle_abort_ignored", 32'(bus.aborted), 32'd0);
    chk("idle_abort_busy",    32'(bus.busy),    32'd0);

    // 0 -> 50 counting up.
    load_cnt(16'd0);
    move(16'd50, 200, e, u, d, a);
    chk("up50_en",    32'(e), 32'd50);
    chk("up50_up",    32'(u), 32'd50);
    chk("up50_done",  32'(d), 32'd1);
    chk("up50_abort", 32'(a), 32'd0);
    chk("up50_cur",   32'(cnt), 32'd50);
    chk("up50_steps", 32'(bus.steps), 32'd50);

    // 50 -> 25 counting down; steps holds in IDLE.
    move(16'd25, 200, e, u, d, a);
    chk("dn25_en",    32'(e), 32'd25);
    chk("dn25_up",    32'(u), 32'd0);
    chk("dn25_done",  32'(d), 32'd1);
    chk("dn25_cur",   32'(cnt), 32'd25);
    @(negedge clk);
    chk("dn25_steps_hold", 32'(bus.steps), 32'd25);

    // Wrap-around 0xFFFE -> 0x0003.
    load_cnt(16'hFFFE);
    move(16'h0003, 200, e, u, d, a);
    chk("wrap_en",    32'(e), 32'd5);
    chk("wrap_up",    32'(u), 32'd5);
    chk("wrap_done",  32'(d), 32'd1);
    chk("wrap_cur",   32'(cnt), 32'h0003);
    chk("wrap_steps", 32'(bus.steps), 32'd5);

    // Target equal to current count; tgt_valid held during RUN; abort in FIN.
    @(negedge clk);
    bus.tgt_data  = 16'h0003;
    bus.tgt_valid = 1'b1;
    @(negedge clk);
    bus.tgt_data  = 16'h0008;
    chk("eq_run_en",    32'(bus.en),        32'd0);
    chk("eq_run_busy",  32'(bus.busy),      32'd1);
    chk("eq_run_ready", 32'(bus.tgt_ready), 32'd0);
    chk("eq_run_done",  32'(bus.done),      32'd0);
    @(negedge clk);
    bus.abort = 1'b1;
    chk("eq_fin_done",  32'(bus.done),      32'd1);
    chk("eq_fin_en",    32'(bus.en),        32'd0);
    chk("eq_fin_ready", 32'(bus.tgt_ready), 32'd0);
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.tgt_valid = 1'b0;
    chk("eq_idle_busy",    32'(bus.busy),    32'd0);
    chk("eq_idle_done",    32'(bus.done),    32'd0);
    chk("eq_fin_abort_ig", 32'(bus.aborted), 32'd0);
    chk("eq_steps",        32'(bus.steps),   32'd0);
    chk("eq_cur",          32'(cnt),         32'h0003);

    // Just past the tie: 0 -> 0x8001 goes down.
    load_cnt(16'd0);
    bus.tgt_data  = 16'h8001;
    bus.tgt_valid = 1'b1;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    chk("past_tie_en", 32'(bus.en), 32'd1);
    chk("past_tie_up", 32'(bus.up), 32'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);

    // Abort after 10 steps of a 0 -> 40 move.
    load_cnt(16'd0);
    bus.tgt_data  = 16'd40;
    bus.tgt_valid = 1'b1;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    wait_cnt(16'd10, 100);
    bus.abort = 1'b1;
    #1;
    chk("ab_en_drop",  32'(bus.en),   32'd0);
    chk("ab_up_drop",  32'(bus.up),   32'd0);
    chk("ab_busy",     32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab_pulse",    32'(bus.aborted), 32'd1);
    chk("ab_no_done",  32'(bus.done),    32'd0);
    chk("ab_idle",     32'(bus.busy),    32'd0);
    chk("ab_cur",      32'(cnt),         32'd10);
    chk("ab_steps",    32'(bus.steps),   32'd10);
    @(negedge clk);
    chk("ab_pulse_end", 32'(bus.aborted), 32'd0);

    // Reset mid-move at count 7, then a new target 3.
    load_cnt(16'd0);
    bus.tgt_data  = 16'd20;
    bus.tgt_valid = 1'b1;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    wait_cnt(16'd7, 100);
    reset = 1'b0;
    #1;
    chk("mr_en",      32'(bus.en),        32'd0);
    chk("mr_busy",    32'(bus.busy),      32'd0);
    chk("mr_ready",   32'(bus.tgt_ready), 32'd1);
    chk("mr_done",    32'(bus.done),      32'd0);
    chk("mr_aborted", 32'(bus.aborted),   32'd0);
    chk("mr_steps",   32'(bus.steps),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("mr_cur_hold", 32'(cnt), 32'd7);
    move(16'd3, 100, e, u, d, a);
    chk("mr3_en",    32'(e), 32'd4);
    chk("mr3_up",    32'(u), 32'd0);
    chk("mr3_done",  32'(d), 32'd1);
    chk("mr3_abort", 32'(a), 32'd0);
    chk("mr3_cur",   32'(cnt), 32'd3);
    chk("mr3_steps", 32'(bus.steps), 32'd4);

    // Tie: 0 -> 0x8000 goes up the whole way.
    load_cnt(16'd0);
    move(16'h8000, 40000, e, u, d, a);
    chk("tie_en",    32'(e), 32'd32768);
    chk("tie_up",    32'(u), 32'd32768);
    chk("tie_done",  32'(d), 32'd1);
    chk("tie_cur",   32'(cnt), 32'h8000);
    chk("tie_steps", 32'(bus.steps), 32'h8000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
